sd_dfc_rx_sched: RTL

Packet-aware round-robin scheduler that shares one srdy/drdy egress between N delayed-flow-control receiver channels. Each channel presents its FIFO head (srdy/drdy/data/eop) and FIFO usage. The block grants one channel per packet and forwards its beats through a one-deep output register, tagging each beat with its channel number. From each channel's usage it also generates the per-channel force_stop with hysteresis, which back-pressures the remote transmitter.

---
 rtl/sd_dfc_rx_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sd_dfc_rx_sched.sv
// Packet-aware round-robin scheduler for N delayed-flow-control rx channels.
// One-deep registered egress, channel tagging and per-channel force_stop.
module sd_dfc_rx_sched #(
  parameter int nch        = 4,
  parameter int width      = 8,
  parameter int usage_sz   = 3,
  parameter int stop_thd   = 5,
  parameter int resume_thd = 2,
  localparam int chw       = $clog2(nch)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [nch-1:0]          c_srdy,
  output logic [nch-1:0]          c_drdy,
  input  logic [nch*width-1:0]    c_data,
  input  logic [nch-1:0]          c_eop,
  input  logic [nch*usage_sz-1:0] c_usage,
  output logic [nch-1:0]          force_stop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic                    p_eop,
  output logic [chw-1:0]          p_chan,
  output logic                    busy
);

  if (resume_thd >= stop_thd || stop_thd > 2**usage_sz-1) begin : g_bad_thd
    $error("sd_dfc_rx_sched: invalid stop/resume thresholds");
  end

  localparam logic [usage_sz-1:0] stop_u   = stop_thd[usage_sz-1:0];
  localparam logic [usage_sz-1:0] resume_u = resume_thd[usage_sz-1:0];

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [chw-1:0]   rr_q, rr_d;
  logic [chw-1:0]   grant_q, grant_d;
  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic             p_eop_q, p_eop_d;
  logic [chw-1:0]   p_chan_q, p_chan_d;
  logic [nch-1:0]   fs_q, fs_d;

  logic             load;
  logic             found;
  logic             pop;
  int               idx;
  logic [nch-1:0]   sel;
  logic [chw-1:0]   sel_idx;
  logic [width-1:0] beat_data;
  logic             beat_eop;
  logic [usage_sz-1:0] u;

  function automatic logic [chw-1:0] inc(input logic [chw-1:0] x);
    return (int'(x) == nch-1) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    load    = ~p_srdy_q | p_drdy;
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state_q == LOCK) begin
      sel[grant_q] = 1'b1;
      sel_idx      = grant_q;
    end else if (en) begin
      for (int k = 0; k < nch; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= nch) idx = idx - nch;
        if (!found && c_srdy[idx]) begin
          found    = 1'b1;
          sel[idx] = 1'b1;
          sel_idx  = chw'(idx);
        end
      end
    end
    c_drdy    = (load && !rst) ? sel : '0;
    pop       = |(c_srdy & c_drdy);
    beat_data = c_data[sel_idx*width +: width];
    beat_eop  = c_eop[sel_idx];
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    p_eop_d  = p_eop_q;
    p_chan_d = p_chan_q;
    if (pop) begin
      p_srdy_d = 1'b1;
      p_data_d = beat_data;
      p_eop_d  = beat_eop;
      p_chan_d = sel_idx;
      if (beat_eop) begin
        state_d = IDLE;
        rr_d    = inc(sel_idx);
      end else begin
        state_d = LOCK;
        grant_d = sel_idx;
      end
    end else if (p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  // Hysteresis: between the thresholds the previous stop level is kept.
  always_comb begin
    fs_d = fs_q;
    u    = '0;
    for (int i = 0; i < nch; i++) begin
      u = c_usage[i*usage_sz +: usage_sz];
      if (u >= stop_u)        fs_d[i] = 1'b1;
      else if (u <= resume_u) fs_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
      p_eop_q  <= 1'b0;
      p_chan_q <= '0;
      fs_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
      p_eop_q  <= p_eop_d;
      p_chan_q <= p_chan_d;
      fs_q     <= fs_d;
    end
  end

  assign p_srdy     = p_srdy_q;
  assign p_data     = p_data_q;
  assign p_eop      = p_eop_q;
  assign p_chan     = p_chan_q;
  assign force_stop = fs_q;
  assign busy       = (state_q == LOCK);

endmodule
